matrix_led_monitor: RTL and testbench
=====================================

MATRIX_LED_MONITOR -- requirements
Module: matrix_led_monitor

Interface
REQ-001 Parameter DATAWIDTH, default 32: width of one result element.
REQ-002 Parameter ELEMS, default 16: element count on the result bus.
REQ-003 Parameter LEDS, default 16: LED outputs; LEDS >= 8.
REQ-004 Parameter DEBOUNCE_CYCLES, default 4: stable cycles needed to accept a button level.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024: maximum BUSY cycles before the error flag sets.
REQ-006 Parameter THRESH, default 1: threshold-map compare value, DATAWIDTH bits.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 btn_load  in  1  raw start button.
REQ-010 btn_next  in  1  raw element-step button.
REQ-011 mode  in  2  display-mode select.
REQ-012 res_in  in  ELEMS*DATAWIDTH  result bus; element k occupies bits [k*DATAWIDTH +: DATAWIDTH].
REQ-013 res_valid  in  1  result-bus-valid strobe from the matrix core.
REQ-014 load  out  1  one-cycle start pulse to the matrix core.
REQ-015 busy  out  1  high while waiting for a result.
REQ-016 timeout  out  1  sticky flag: the last run timed out.
REQ-017 led  out  LEDS  registered display output.

Function
REQ-018 Each button SHALL pass a debouncer: the accepted level changes only after the raw input holds the new value for DEBOUNCE_CYCLES consecutive cycles.
REQ-019 A 0->1 change of an accepted level SHALL produce exactly one one-cycle pulse (load_p, next_p); holding the button SHALL produce no further pulses.
REQ-020 The FSM SHALL have states IDLE, BUSY, SHOW.
REQ-021 IDLE or SHOW with load_p SHALL go to BUSY, assert load for that one cycle, clear timeout and clear the BUSY cycle counter.
REQ-022 BUSY with res_valid SHALL capture res_in into the snapshot register and go to SHOW.
REQ-023 BUSY with the counter reaching TIMEOUT_CYCLES-1 and no res_valid SHALL set timeout and go to IDLE; the snapshot is unchanged.
REQ-024 If res_valid and timeout expiry occur in the same cycle, the capture SHALL win and timeout SHALL stay 0.
REQ-025 res_valid outside BUSY SHALL be ignored; load_p in BUSY SHALL be ignored.
REQ-026 busy SHALL equal (state == BUSY), registered.
REQ-027 Index idx ($clog2(ELEMS) bits) SHALL increment on next_p and wrap from ELEMS-1 to 0, in any state.
REQ-028 mode 0: led[i] = (snap[i] >= THRESH) unsigned, for i < min(ELEMS,LEDS); all other LEDs 0.
REQ-029 mode 1: led = snap[idx][LEDS-1:0], zero-extended if DATAWIDTH < LEDS.
REQ-030 mode 2: led = snap[idx][2*LEDS-1:LEDS] when DATAWIDTH >= 2*LEDS, otherwise the available upper bits zero-extended, or 0 if none.
REQ-031 mode 3: led[0]=busy, led[1]=timeout, led[2]=(state==SHOW), led[7:3]=0, led[LEDS-1:8] = idx zero-extended or truncated.
REQ-032 led SHALL update one cycle after any change of snapshot, mode, idx or status.

Reset
REQ-033 rst SHALL force: state IDLE, load 0, busy 0, timeout 0, led 0, snapshot 0, idx 0, counters 0, debounced levels 0.
REQ-034 rst mid-BUSY SHALL abandon the run with no load pulse; a res_valid arriving later SHALL be ignored.

Structure
REQ-035 The FSM state encoding and the mode codes (MODE_THRESH, MODE_LO, MODE_HI, MODE_STATUS) SHALL live in a shared package.
REQ-036 Debounce and edge detection SHALL be one sub-module, btn_debounce (parameter DEBOUNCE_CYCLES), instantiated twice.

Verification
REQ-037 btn_load high for 3 cycles (DEBOUNCE_CYCLES=4) -> no load pulse; high for 10 cycles -> exactly one load pulse, busy=1 from the next cycle.
REQ-038 In BUSY, res_valid with elements 0..15 = 1..16, mode 0 -> led=16'hFFFF; with element 5 = 0 -> led=16'hFFDF.
REQ-039 After capture, mode 1, five next presses -> idx=5, led = element 5 low bits; 16 more presses -> idx wraps to 5.
REQ-040 TIMEOUT_CYCLES=8, no res_valid -> timeout=1 and state IDLE after 8 BUSY cycles, snapshot unchanged; res_valid on the 8th cycle -> capture, timeout=0.
REQ-041 rst pulsed mid-BUSY, then res_valid -> all outputs 0, snapshot stays 0.
REQ-042 mode 3 in SHOW with idx=3 -> led=16'h0304.

Source files
------------

// File: rtl/matrix_led_monitor_pkg.sv
// Shared types and constants for the matrix LED monitor: FSM state
// encoding, display-mode codes and a small elaboration helper.
package matrix_led_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [1:0] MODE_THRESH = 2'd0;
    localparam logic [1:0] MODE_LO     = 2'd1;
    localparam logic [1:0] MODE_HI     = 2'd2;
    localparam logic [1:0] MODE_STATUS = 2'd3;

    // Smaller of two integers, used to size loops at elaboration time.
    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/matrix_led_monitor_if.sv
// Handshake between the LED monitor and the matrix core: the monitor
// issues a start pulse and receives the full result bus with a valid strobe.
interface matrix_led_monitor_if #(
    parameter int DATAWIDTH = 32,
    parameter int ELEMS     = 16
);
    logic                       load;
    logic [ELEMS*DATAWIDTH-1:0] res_in;
    logic                       res_valid;

    // Monitor side: starts runs, consumes results.
    modport master (output load, input res_in, input res_valid);
    // Matrix core side: accepts start, produces results.
    modport slave  (input load, output res_in, output res_valid);
endinterface

// File: rtl/matrix_led_monitor_btn_debounce.sv
// Button conditioner: accepts a new raw level only after it has been
// stable for DEBOUNCE_CYCLES cycles, and emits a single-cycle pulse on
// each accepted 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          level_r;
    logic [CW-1:0] cnt_r;
    logic          pulse_r;
    logic          accept_s;

    // Raw input has differed from the accepted level long enough.
    always_comb begin
        accept_s = (btn_raw != level_r) && (cnt_r == CW'(DEBOUNCE_CYCLES - 1));
    end

    // Stability counter, accepted level and rising-edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            pulse_r <= 1'b0;
        end else begin
            if (btn_raw == level_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (accept_s) begin
                cnt_r   <= {CW{1'b0}};
                level_r <= btn_raw;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            pulse_r <= accept_s & btn_raw;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/matrix_led_monitor.sv
// Matrix LED monitor: debounced buttons start a matrix-core run and step
// through result elements; the captured result bus is rendered on the LEDs
// in one of four display modes.
module matrix_led_monitor
    import matrix_led_monitor_pkg::*;
#(
    parameter int                   DATAWIDTH       = 32,
    parameter int                   ELEMS           = 16,
    parameter int                   LEDS            = 16,
    parameter int                   DEBOUNCE_CYCLES = 4,
    parameter int                   TIMEOUT_CYCLES  = 1024,
    parameter logic [DATAWIDTH-1:0] THRESH          = DATAWIDTH'(1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_load,
    input  logic                     btn_next,
    input  logic [1:0]               mode,
    matrix_led_monitor_if.master     core,
    output logic                     busy,
    output logic                     timeout,
    output logic [LEDS-1:0]          led
);
    localparam int IDXW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int NTH  = min_int(ELEMS, LEDS);

    state_t                state_r, state_n;
    logic                  load_p_s, next_p_s;
    logic                  load_s, capture_s, expire_s, clear_s;
    logic                  load_r, busy_r, timeout_r;
    logic [CNTW-1:0]       cnt_r;
    logic [IDXW-1:0]       idx_r;
    logic [DATAWIDTH-1:0]  snap_r [ELEMS];
    logic [DATAWIDTH-1:0]  elem_s;
    logic [LEDS-1:0]       led_s, led_r;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk(clk), .rst(rst), .btn_raw(btn_load), .pulse(load_p_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(clk), .rst(rst), .btn_raw(btn_next), .pulse(next_p_s)
    );

    // Next-state and run-control decode; a result arriving on the last
    // allowed BUSY cycle takes priority over the timeout.
    always_comb begin
        state_n   = state_r;
        load_s    = 1'b0;
        capture_s = 1'b0;
        expire_s  = 1'b0;
        clear_s   = 1'b0;
        case (state_r)
            IDLE, SHOW: begin
                if (load_p_s) begin
                    state_n = BUSY;
                    load_s  = 1'b1;
                    clear_s = 1'b1;
                end else begin
                    state_n = state_r;
                end
            end
            BUSY: begin
                if (core.res_valid) begin
                    state_n   = SHOW;
                    capture_s = 1'b1;
                end else if (cnt_r == CNTW'(TIMEOUT_CYCLES - 1)) begin
                    state_n  = IDLE;
                    expire_s = 1'b1;
                end else begin
                    state_n = BUSY;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, start pulse, busy/timeout flags and BUSY cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            load_r    <= 1'b0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            cnt_r     <= {CNTW{1'b0}};
        end else begin
            state_r <= state_n;
            load_r  <= load_s;
            busy_r  <= (state_n == BUSY);
            if (clear_s) begin
                timeout_r <= 1'b0;
            end else if (expire_s) begin
                timeout_r <= 1'b1;
            end
            if (clear_s) begin
                cnt_r <= {CNTW{1'b0}};
            end else if (state_r == BUSY) begin
                cnt_r <= cnt_r + CNTW'(1);
            end
        end
    end

    // Result snapshot, loaded only when a run completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ELEMS; k++) begin
                snap_r[k] <= {DATAWIDTH{1'b0}};
            end
        end else if (capture_s) begin
            for (int k = 0; k < ELEMS; k++) begin
                snap_r[k] <= core.res_in[k*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Element index, stepped by the next button in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= {IDXW{1'b0}};
        end else if (next_p_s) begin
            if (idx_r == IDXW'(ELEMS - 1)) begin
                idx_r <= {IDXW{1'b0}};
            end else begin
                idx_r <= idx_r + IDXW'(1);
            end
        end
    end

    // Currently selected snapshot element.
    always_comb begin
        elem_s = snap_r[idx_r];
    end

    // Display image for the selected mode; size casts give zero-extension
    // or truncation when element and LED widths differ.
    always_comb begin
        led_s = {LEDS{1'b0}};
        case (mode)
            MODE_THRESH: begin
                for (int i = 0; i < NTH; i++) begin
                    led_s[i] = (snap_r[i] >= THRESH);
                end
            end
            MODE_LO: led_s = LEDS'(elem_s);
            MODE_HI: led_s = LEDS'(elem_s >> LEDS);
            MODE_STATUS: begin
                led_s    = LEDS'(idx_r) << 4'd8;
                led_s[0] = busy_r;
                led_s[1] = timeout_r;
                led_s[2] = (state_r == SHOW);
            end
            default: led_s = {LEDS{1'b0}};
        endcase
    end

    // Registered LED output.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r <= {LEDS{1'b0}};
        end else begin
            led_r <= led_s;
        end
    end

    assign core.load = load_r;
    assign busy      = busy_r;
    assign timeout   = timeout_r;
    assign led       = led_r;

endmodule

// File: tb/tb_matrix_led_monitor.sv
// Self-checking bench for matrix_led_monitor: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_matrix_led_monitor;
    localparam int DW  = 32;
    localparam int EL  = 16;
    localparam int LD  = 16;
    localparam int DEB = 4;
    localparam int TO  = 8;

    logic          clk = 1'b0;
    logic          rst, btn_load, btn_next;
    logic [1:0]    mode;
    logic          busy, timeout;
    logic [LD-1:0] led;

    matrix_led_monitor_if #(.DATAWIDTH(DW), .ELEMS(EL)) core_if ();

    matrix_led_monitor #(
        .DATAWIDTH(DW), .ELEMS(EL), .LEDS(LD), .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES(TO), .THRESH(32'd1)
    ) dut (
        .clk(clk), .rst(rst), .btn_load(btn_load), .btn_next(btn_next),
        .mode(mode), .core(core_if), .busy(busy), .timeout(timeout), .led(led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] elems [EL];

    // Behavioural model: state 0 idle, 1 waiting, 2 showing.
    int          m_state;
    bit          m_load, m_busy, m_to;
    int          m_bcyc;
    logic [31:0] m_snap [EL];
    int          m_idx;
    logic [15:0] m_led;
    bit          m_lvl [2];
    int          m_run [2];
    bit          m_pul [2];

    function automatic logic [15:0] model_led(input int md);
        logic [15:0] r;
        logic [31:0] e;
        logic [7:0]  ix;
        r  = 16'h0000;
        e  = m_snap[m_idx];
        ix = 8'(m_idx);
        case (md)
            0: for (int i = 0; i < 16; i++) r[i] = (m_snap[i] >= 32'd1);
            1: r = e[15:0];
            2: r = e[31:16];
            default: r = {ix, 5'b00000, (m_state == 2), m_to, m_busy};
        endcase
        return r;
    endfunction

    function automatic void model_update();
        logic [15:0] nled;
        bit lp, np;
        bit raw [2];
        if (rst) begin
            m_state = 0; m_load = 0; m_busy = 0; m_to = 0; m_bcyc = 0;
            m_idx = 0; m_led = 16'h0000;
            for (int k = 0; k < EL; k++) m_snap[k] = 32'd0;
            for (int b = 0; b < 2; b++) begin m_lvl[b] = 0; m_run[b] = 0; m_pul[b] = 0; end
        end else begin
            nled   = model_led(int'(mode));
            lp     = m_pul[0];
            np     = m_pul[1];
            raw[0] = btn_load;
            raw[1] = btn_next;
            m_load = 0;
            if (m_state != 1 && lp) begin
                m_state = 1; m_load = 1; m_to = 0; m_bcyc = 0;
            end else if (m_state == 1) begin
                m_bcyc++;
                if (core_if.res_valid) begin
                    for (int k = 0; k < EL; k++) m_snap[k] = elems[k];
                    m_state = 2;
                end else if (m_bcyc == TO) begin
                    m_to = 1; m_state = 0;
                end
            end
            m_busy = (m_state == 1);
            if (np) m_idx = (m_idx + 1) % EL;
            for (int b = 0; b < 2; b++) begin
                m_pul[b] = 0;
                if (raw[b] == m_lvl[b]) begin
                    m_run[b] = 0;
                end else begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_lvl[b] = raw[b]; m_run[b] = 0; m_pul[b] = raw[b];
                    end
                end
            end
            m_led = nled;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_res();
        for (int k = 0; k < EL; k++) core_if.res_in[k*DW +: DW] = elems[k];
    endtask

    task automatic press_load();
        btn_load = 1'b0;
        repeat (DEB + 1) step();
        btn_load = 1'b1;
        repeat (DEB + 1) step();
        btn_load = 1'b0;
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        repeat (DEB + 1) step();
        btn_next = 1'b0;
        repeat (DEB + 1) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'd3;
        repeat (3) step();
        n_checks++; if (core_if.load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b want 0", core_if.load); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        n_checks++; if (led !== 16'h0000) begin n_fail++; $display("FAIL reset_led: got %h want 0000", led); end
        rst = 1'b0;
        step(); step();
        n_checks++; if (led !== 16'h0000) begin n_fail++; $display("FAIL idle_status_led: got %h want 0000", led); end
        mode = 2'd0;
    endtask

    task automatic test_debounce();
        int cnt;
        bit prev;
        btn_load = 1'b1;
        repeat (3) step();
        btn_load = 1'b0;
        cnt = 0;
        repeat (10) begin step(); if (core_if.load === 1'b1) cnt++; end
        n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL short_press_pulses: got %0d want 0", cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL short_press_busy: got %b want 0", busy); end
        cnt = 0; prev = 0;
        for (int c = 0; c < 16; c++) begin
            btn_load = (c < 10);
            step();
            if (prev) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_load: got %b want 1", busy); end
            end
            prev = (core_if.load === 1'b1);
            if (prev) cnt++;
        end
        n_checks++; if (cnt != 1) begin n_fail++; $display("FAIL long_press_pulses: got %0d want 1", cnt); end
        n_checks++; if (timeout !== 1'b1 || m_to !== 1'b1) begin n_fail++; $display("FAIL long_press_timeout: got %b want 1", timeout); end
    endtask

    task automatic test_capture_thresh();
        press_load();
        n_checks++; if (busy !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL run_start: got busy=%b timeout=%b want 1 0", busy, timeout); end
        for (int k = 0; k < EL; k++) elems[k] = 32'(k + 1);
        drive_res(); core_if.res_valid = 1'b1; step(); core_if.res_valid = 1'b0;
        mode = 2'd0; step(); step();
        n_checks++; if (led !== 16'hFFFF) begin n_fail++; $display("FAIL thresh_all: got %h want ffff", led); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL capture_busy: got %b want 0", busy); end
        press_load();
        elems[5] = 32'd0;
        drive_res(); core_if.res_valid = 1'b1; step(); core_if.res_valid = 1'b0;
        step(); step();
        n_checks++; if (led !== 16'hFFDF || led !== m_led) begin n_fail++; $display("FAIL thresh_elem5: got %h want ffdf", led); end
    endtask

    task automatic test_index();
        logic [31:0] e5;
        press_load();
        for (int k = 0; k < EL; k++) elems[k] = $urandom;
        e5 = elems[5];
        drive_res(); core_if.res_valid = 1'b1; step(); core_if.res_valid = 1'b0;
        mode = 2'd1;
        repeat (5) press_next();
        step();
        n_checks++; if (led !== e5[15:0]) begin n_fail++; $display("FAIL idx5_lo: got %h want %h", led, e5[15:0]); end
        mode = 2'd2; step(); step();
        n_checks++; if (led !== e5[31:16]) begin n_fail++; $display("FAIL idx5_hi: got %h want %h", led, e5[31:16]); end
        mode = 2'd1;
        repeat (16) press_next();
        step();
        n_checks++; if (led !== e5[15:0] || m_idx != 5) begin n_fail++; $display("FAIL idx_wrap_lo: got %h want %h", led, e5[15:0]); end
    endtask

    task automatic test_status();
        mode = 2'd3;
        repeat (14) press_next();
        step();
        n_checks++; if (led !== 16'h0304 || led !== m_led) begin n_fail++; $display("FAIL status_idx3: got %h want 0304", led); end
    endtask

    task automatic test_timeout();
        logic [31:0] e3;
        e3 = elems[3];
        mode = 2'd1;
        press_load();
        for (int k = 0; k < EL; k++) elems[k] = $urandom;
        drive_res();
        repeat (7) step();
        n_checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL pre_expiry: got busy=%b timeout=%b want 1 0", busy, timeout); end
        step();
        n_checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL expiry: got busy=%b timeout=%b want 0 1", busy, timeout); end
        step(); step();
        n_checks++; if (led !== e3[15:0]) begin n_fail++; $display("FAIL snap_kept: got %h want %h", led, e3[15:0]); end
    endtask

    task automatic test_timeout_race();
        logic [31:0] e3;
        press_load();
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_cleared: got %b want 0", timeout); end
        repeat (7) step();
        for (int k = 0; k < EL; k++) elems[k] = $urandom;
        e3 = elems[3];
        drive_res(); core_if.res_valid = 1'b1; step(); core_if.res_valid = 1'b0;
        n_checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL race: got busy=%b timeout=%b want 0 0", busy, timeout); end
        step(); step();
        n_checks++; if (led !== e3[15:0]) begin n_fail++; $display("FAIL race_capture: got %h want %h", led, e3[15:0]); end
    endtask

    task automatic test_reset_mid_busy();
        press_load();
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < EL; k++) elems[k] = $urandom | 32'h0001_0001;
        drive_res(); core_if.res_valid = 1'b1; step(); core_if.res_valid = 1'b0;
        for (int md = 0; md < 4; md++) begin
            mode = 2'(md);
            step(); step();
            n_checks++; if (led !== 16'h0000) begin n_fail++; $display("FAIL rst_busy_led_mode%0d: got %h want 0000", md, led); end
        end
        n_checks++; if (busy !== 1'b0 || timeout !== 1'b0 || core_if.load !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy_flags: got busy=%b timeout=%b load=%b want 0 0 0", busy, timeout, core_if.load);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) btn_load = ~btn_load;
            if ($urandom_range(0, 5) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            core_if.res_valid = ($urandom_range(0, 7) == 0);
            if (core_if.res_valid) begin
                for (int k = 0; k < EL; k++) elems[k] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2)) : $urandom;
                drive_res();
            end
            rst = ($urandom_range(0, 149) == 0);
            step();
            n_checks++; if (core_if.load !== m_load) begin n_fail++; $display("FAIL rnd_load c=%0d: got %b want %b", c, core_if.load, m_load); end
            n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, m_busy); end
            n_checks++; if (timeout !== m_to) begin n_fail++; $display("FAIL rnd_timeout c=%0d: got %b want %b", c, timeout, m_to); end
            n_checks++; if (led !== m_led) begin n_fail++; $display("FAIL rnd_led c=%0d: got %h want %h", c, led, m_led); end
        end
        rst = 1'b0; core_if.res_valid = 1'b0; btn_load = 1'b0; btn_next = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_load = 1'b0; btn_next = 1'b0; mode = 2'd0;
        core_if.res_valid = 1'b0;
        for (int k = 0; k < EL; k++) elems[k] = 32'd0;
        drive_res();
        test_reset();
        test_debounce();
        test_capture_thresh();
        test_index();
        test_status();
        test_timeout();
        test_timeout_race();
        test_reset_mid_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
